eda_result_streamer: RTL and testbench
======================================

EDA_RESULT_STREAMER -- requirements
Module: eda_result_streamer

Interface
REQ-001 SHALL have parameter M, default 8: number of result rows.
REQ-002 SHALL have parameter N, default 8: number of result columns (bits per row).
REQ-003 SHALL have parameter I_WIDTH, default 3: row index width; SHALL satisfy 2**I_WIDTH >= M.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port done, input, 1: one-cycle pulse from eda_regional_max meaning matrix_output is final.
REQ-007 SHALL have port matrix_output, input, [M-1:0][N-1:0]: regional-max result; bit [i][j] marks pixel (i,j).
REQ-008 SHALL have port row_valid, output, 1: row_data, row_idx and row_last are valid.
REQ-009 SHALL have port row_ready, input, 1: consumer accepts the current row.
REQ-010 SHALL have port row_data, output, N: matrix_output[row_idx] as captured.
REQ-011 SHALL have port row_idx, output, I_WIDTH: index of the row being offered.
REQ-012 SHALL have port row_last, output, 1: high with the row where row_idx == M-1.
REQ-013 SHALL have port busy, output, 1: high while a captured frame is not fully drained.
REQ-014 SHALL have port overrun, output, 1: sticky, set when done arrives while busy.
REQ-015 SHALL have port frame_cnt, output, 8: count of completely drained frames, wraps 255 -> 0.

Function
REQ-016 SHALL implement FSM states IDLE and SEND.
REQ-017 In IDLE with done=1, SHALL capture all of matrix_output into an internal M x N register, set row pointer to 0, and enter SEND on the same edge.
REQ-018 row_valid SHALL be 1 exactly in SEND; first row offered the cycle after done (latency 1).
REQ-019 A beat transfers when row_valid && row_ready on a rising edge; row_data, row_idx and row_last SHALL hold stable while row_valid && !row_ready.
REQ-020 On a transfer with row_idx < M-1, row_idx SHALL increment by 1 and the next row SHALL be offered the following cycle (back-to-back throughput 1 row/cycle).
REQ-021 On a transfer with row_idx == M-1, SHALL return to IDLE, deassert row_valid next cycle and increment frame_cnt by 1.
REQ-022 row_data SHALL come only from the captured register; changes on matrix_output after capture SHALL NOT affect the frame.
REQ-023 busy SHALL equal (state == SEND).
REQ-024 done while in SEND (including the cycle of the last transfer) SHALL be ignored (no re-capture, no pointer change) and SHALL set overrun to 1.
REQ-025 done in IDLE SHALL NOT modify overrun; overrun clears only on reset.
REQ-026 With M == 1, the single row SHALL be offered with row_last=1 and row_idx=0.
REQ-027 row_ready while row_valid=0 SHALL have no effect.

Reset
REQ-028 reset=1 at a rising edge SHALL force: state IDLE, row_valid 0, row_idx 0, row_last 0, row_data 0, busy 0, overrun 0, frame_cnt 0, captured register 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without completing it; frame_cnt SHALL NOT increment.
REQ-030 done coincident with reset SHALL be ignored.

Verification (M=4, N=4)
REQ-031 Basic: matrix_output rows {4'b0001,4'b0010,4'b0100,4'b1000}, done pulse, row_ready=1 -> rows 0..3 on 4 consecutive cycles starting 1 cycle after done, row_last only on idx 3, frame_cnt=1, busy low after.
REQ-032 Backpressure: row_ready toggled 1,0,0,1,... -> each row held stable while stalled, order 0..3 preserved, no row lost or duplicated.
REQ-033 Capture isolation: change matrix_output to all 1 one cycle after done -> streamed rows equal the pre-change values.
REQ-034 Overrun: second done while row_idx=1 -> overrun=1, frame continues unchanged, frame_cnt=1 at end; done on the last-transfer cycle also sets overrun.
REQ-035 Reset mid-frame: reset at row_idx=2 -> all outputs at reset values next cycle, frame_cnt=0; a new done then streams a full frame normally.
REQ-036 Wrap: 256 back-to-back frames -> frame_cnt returns to 0.

Source files
------------

// File: rtl/eda_result_streamer.sv
// ---------------------------------------------------------------------------
// eda_result_streamer
//
// Captures the final regional-max result matrix when eda_regional_max pulses
// `done`, then streams it out one row per beat over a valid/ready handshake.
// The matrix is snapshotted on capture. Later changes on matrix_output do not
// reach the rows being streamed.
//
// Parameters
//   M        number of result rows
//   N        number of result columns (bits per row)
//   I_WIDTH  row index width, 2**I_WIDTH >= M
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   done           one-cycle pulse: matrix_output is final
//   matrix_output  [M-1:0][N-1:0] result, bit [i][j] marks pixel (i,j)
//   row_valid      row_data / row_idx / row_last are valid
//   row_ready      consumer accepts the current row
//   row_data       captured row row_idx
//   row_idx        index of the row being offered
//   row_last       high with the row where row_idx == M-1
//   busy           a captured frame is not fully drained
//   overrun        sticky: done arrived while busy (cleared only by reset)
//   frame_cnt      completely drained frames, wraps 255 -> 0
// ---------------------------------------------------------------------------
module eda_result_streamer #(
  parameter int M       = 8,
  parameter int N       = 8,
  parameter int I_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      done,
  input  logic [M-1:0][N-1:0]       matrix_output,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic [N-1:0]              row_data,
  output logic [I_WIDTH-1:0]        row_idx,
  output logic                      row_last,
  output logic                      busy,
  output logic                      overrun,
  output logic [7:0]                frame_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [I_WIDTH-1:0] LAST_IDX = I_WIDTH'(M - 1);

  state_t                 state_q, state_d;
  logic [M-1:0][N-1:0]    cap_q;
  logic [I_WIDTH-1:0]     ptr_q;
  logic                   overrun_q;
  logic [7:0]             frame_cnt_q;

  // Datapath controls decoded by the next-state logic.
  logic capture;   // snapshot the matrix and start a frame
  logic advance;   // move to the next row
  logic finish;    // last row accepted, frame complete

  // -------------------------------------------------------------------------
  // Next-state / control decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (done) begin
          capture = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // A done seen here is deliberately not acted on. It only raises
        // overrun in the register block.
        if (row_ready) begin
          if (ptr_q == LAST_IDX) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (reset) begin
      // NOTE: the capture register is reset as well. Otherwise row_data
      // would show stale pixels after reset and would not read as zero.
      state_q     <= IDLE;
      cap_q       <= '0;
      ptr_q       <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;

      if (capture) begin
        cap_q <= matrix_output;
        ptr_q <= '0;
      end

      if (advance) begin
        ptr_q <= ptr_q + I_WIDTH'(1);
      end

      if (finish) begin
        ptr_q       <= '0;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end

      // Sticky. This includes a done on the cycle of the last transfer.
      if ((state_q == SEND) && done) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign row_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign row_idx   = ptr_q;
  assign row_data  = cap_q[ptr_q];
  // Gated by SEND so that M == 1 still gives row_last = 0 out of reset.
  assign row_last  = (state_q == SEND) && (ptr_q == LAST_IDX);
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eda_result_streamer.sv
// ---------------------------------------------------------------------------
// tb_eda_result_streamer
//
// Bench for eda_result_streamer with M=4, N=4. A frame-level reference model
// tracks four values: the captured frame, the position within it, the
// drained-frame count and the sticky overrun. Each cycle the bench compares
// the DUT against this model. Directed scenarios run first, then random
// stimulus.
// ---------------------------------------------------------------------------
module tb_eda_result_streamer;

  localparam int M       = 4;
  localparam int N       = 4;
  localparam int I_WIDTH = 2;

  logic                  clk;
  logic                  reset;
  logic                  done;
  logic [M-1:0][N-1:0]   matrix_output;
  logic                  row_valid;
  logic                  row_ready;
  logic [N-1:0]          row_data;
  logic [I_WIDTH-1:0]    row_idx;
  logic                  row_last;
  logic                  busy;
  logic                  overrun;
  logic [7:0]            frame_cnt;

  eda_result_streamer #(.M(M), .N(N), .I_WIDTH(I_WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .done          (done),
    .matrix_output (matrix_output),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .row_data      (row_data),
    .row_idx       (row_idx),
    .row_last      (row_last),
    .busy          (busy),
    .overrun       (overrun),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame-level view of the streamer.
  bit         m_busy;
  logic [3:0] m_frame [M];
  int         m_pos;
  int         m_cnt;
  bit         m_ovr;
  bit         m_just_reset;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit dn, input bit rdy,
                            input logic [M-1:0][N-1:0] mat);
    m_just_reset = rst;
    if (rst) begin
      m_busy = 0; m_pos = 0; m_cnt = 0; m_ovr = 0;
      for (int i = 0; i < M; i++) m_frame[i] = '0;
    end else if (m_busy) begin
      if (dn) m_ovr = 1;
      if (rdy) begin
        if (m_pos == M - 1) begin
          m_busy = 0;
          m_cnt  = (m_cnt + 1) % 256;
        end else begin
          m_pos++;
        end
      end
    end else if (dn) begin
      for (int i = 0; i < M; i++) m_frame[i] = mat[i];
      m_pos  = 0;
      m_busy = 1;
    end
  endtask

  task automatic compare_all();
    check("row_valid", row_valid, m_busy);
    check("busy", busy, m_busy);
    check("overrun", overrun, m_ovr);
    check("frame_cnt", frame_cnt, m_cnt);
    if (m_busy) begin
      check("row_data", row_data, m_frame[m_pos]);
      check("row_idx", row_idx, m_pos);
      check("row_last", row_last, (m_pos == M - 1));
    end
    if (m_just_reset) begin
      check("rst_row_data", row_data, 0);
      check("rst_row_idx", row_idx, 0);
      check("rst_row_last", row_last, 0);
    end
  endtask

  // Called at a falling edge. Applies inputs across one rising edge, then
  // checks the outcome at the next falling edge.
  task automatic cycle(input bit rst, input bit dn, input bit rdy,
                       input logic [M-1:0][N-1:0] mat);
    reset         = rst;
    done          = dn;
    row_ready     = rdy;
    matrix_output = mat;
    model_step(rst, dn, rdy, mat);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  logic [M-1:0][N-1:0] pat;
  bit                  bp [4] = '{1, 0, 0, 1};

  initial begin
    reset = 1'b1; done = 1'b0; row_ready = 1'b0; matrix_output = '0;
    m_busy = 0; m_pos = 0; m_cnt = 0; m_ovr = 0; m_just_reset = 0;
    for (int i = 0; i < M; i++) m_frame[i] = '0;
    @(negedge clk);

    // Reset state
    cycle(1, 0, 0, '0);
    cycle(1, 1, 1, 16'hFFFF);     // done coincident with reset is ignored
    check("rst_valid", row_valid, 0);
    check("rst_cnt", frame_cnt, 0);

    // Basic frame: the identity diagonal, full throughput
    pat = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    cycle(0, 1, 1, pat);
    for (int k = 0; k < M; k++) begin
      check("basic_idx", row_idx, k);
      check("basic_data", row_data, 1 << k);
      check("basic_last", row_last, (k == M - 1));
      cycle(0, 0, 1, pat);
    end
    check("basic_done_valid", row_valid, 0);
    check("basic_done_busy", busy, 0);
    check("basic_done_cnt", frame_cnt, 1);

    // Backpressure with ready pattern 1,0,0,1 repeating
    pat = 16'h5A3C;
    cycle(0, 1, 0, pat);
    for (int k = 0; k < 10; k++) cycle(0, 0, bp[k % 4], pat);
    check("bp_cnt", frame_cnt, 2);

    // Capture isolation: input goes all ones right after capture
    pat = 16'h1234;
    cycle(0, 1, 0, pat);
    for (int k = 0; k < M; k++) begin
      check("iso_data", row_data, pat[k]);
      cycle(0, 0, 1, 16'hFFFF);
    end

    // Overrun: second done while row_idx == 1
    pat = 16'h9C63;
    cycle(0, 1, 1, pat);
    cycle(0, 0, 1, pat);
    check("ovr_at_idx1", row_idx, 1);
    cycle(0, 1, 1, 16'hFFFF);
    check("ovr_set", overrun, 1);
    check("ovr_frame_kept", row_data, pat[2]);
    cycle(0, 0, 1, pat);
    cycle(0, 0, 1, pat);
    check("ovr_cnt", frame_cnt, 4);

    // Overrun raised by done on the last-transfer cycle
    cycle(1, 0, 0, '0);
    cycle(0, 1, 1, pat);
    for (int k = 0; k < M - 1; k++) cycle(0, 0, 1, pat);
    cycle(0, 1, 1, 16'hFFFF);
    check("ovr_last_set", overrun, 1);
    check("ovr_last_idle", row_valid, 0);
    cycle(0, 1, 1, 16'h0F0F);     // done in IDLE: overrun stays set
    for (int k = 0; k < M; k++) cycle(0, 0, 1, '0);

    // Reset mid-frame at row_idx == 2, then a normal frame
    cycle(1, 0, 0, '0);
    cycle(0, 1, 1, 16'hBEEF);
    cycle(0, 0, 1, 16'hBEEF);
    cycle(0, 0, 1, 16'hBEEF);
    check("midrst_idx2", row_idx, 2);
    cycle(1, 0, 1, 16'hBEEF);
    check("midrst_cnt", frame_cnt, 0);
    check("midrst_data", row_data, 0);
    cycle(0, 1, 1, 16'hCAFE);
    for (int k = 0; k < M; k++) cycle(0, 0, 1, 16'hCAFE);
    check("midrst_cnt_after", frame_cnt, 1);

    // Wrap: 256 back-to-back frames from a fresh reset
    cycle(1, 0, 0, '0);
    for (int f = 0; f < 256; f++) begin
      pat = $urandom;
      cycle(0, 1, 1, pat);
      for (int k = 0; k < M; k++) cycle(0, 0, 1, pat);
      if (f == 254) check("wrap_255", frame_cnt, 255);
    end
    check("wrap_cnt", frame_cnt, 0);
    check("wrap_ovr", overrun, 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) == 0),
            $urandom_range(0, 1),
            $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
